hwpe_stream_rr_burst_arbiter: RTL and testbench
===============================================

Name: hwpe_stream_rr_burst_arbiter

Overview:
- Shares one HWPE-Stream sink among NB_IN requesting source streams.
- The shared sink is typically the push side of an early-stall FIFO in front of a streamer or engine.
- Arbitration is round-robin. The winner holds a lock for up to MAX_BURST beats, so bursts stay contiguous in the FIFO.
- Data and strobe pass through combinationally from the granted input. Arbitration decisions are registered.

Parameters:
- NB_IN, 4, number of requesting input streams (2..16).
- DATA_WIDTH, 32, stream data width (multiple of 32); strb width is DATA_WIDTH/8.
- MAX_BURST, 4, maximum beats per grant (1..256).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- clear_i  in  1  synchronous soft clear; same effect as rst_i.
- push_i[NB_IN]  sink intf array  DATA_WIDTH+DATA_WIDTH/8+2 each  requester streams (valid, ready, data, strb).
- pop_o  source intf  DATA_WIDTH+DATA_WIDTH/8+2  arbitrated output stream to the FIFO.
- grant_idx_o  out  $clog2(NB_IN)  index of the currently locked input; 0 when idle.
- busy_o  out  1  1 while in state LOCK.

Behaviour:
- Reset: rst_i=1 at a clock edge sets state IDLE, rr_ptr=0, burst_cnt=0, grant_idx_q=0. clear_i identical; rst_i has priority.
- Outputs in IDLE:
  - pop_o.valid=0, pop_o.data=0, pop_o.strb=0.
  - all push_i[k].ready=0.
  - busy_o=0, grant_idx_o=0.
- Selection in IDLE: winner = first k with push_i[k].valid=1, searching cyclically from rr_ptr (rr_ptr, rr_ptr+1 … mod NB_IN).
  - If a winner exists: next cycle state=LOCK, grant_idx_q=winner, burst_cnt=0.
  - Otherwise stay IDLE.
  - Arbitration bubble is exactly 1 cycle.
- LOCK, datapath (combinational, zero latency):
  - pop_o.valid = push_i[g].valid; pop_o.data and pop_o.strb = push_i[g] fields when valid, else 0.
  - push_i[g].ready = pop_o.ready; all other readies are 0.
- LOCK, beat: push_i[g].valid & pop_o.ready increments burst_cnt.
- LOCK release conditions (state→IDLE next cycle; rr_ptr = g+1 mod NB_IN):
  - (a) a beat occurs with burst_cnt == MAX_BURST-1;
  - (b) push_i[g].valid=0 while pop_o.ready=1 (source ran dry).
- Backpressure: pop_o.valid=1 with pop_o.ready=0 holds the lock indefinitely. Data stays stable and no counter changes.
- Lock stability: a winner's data is never interleaved with another input inside one burst.
- Handshake compliance: once pop_o.valid=1 is raised in LOCK, it is not dropped until the handshake completes, provided the source obeys the stream protocol.
- Widths: burst_cnt is $clog2(MAX_BURST+1) bits and never exceeds MAX_BURST-1. rr_ptr wraps from NB_IN-1 to 0.
- MAX_BURST=1: every beat releases, giving strict beat-level round-robin with a bubble between beats.
- Reset or clear mid-burst: the beat in that cycle is completed on the combinational handshake. State is forced to IDLE next cycle and no further beats are granted.
- No invalid state encodings are reachable. Default branch → IDLE with all readies 0.

Optional Feature:
- Macro: HWPE_STREAM_RR_PRIO_EN.
- When defined:
  - Adds input port prio_mask_i [NB_IN].
  - In IDLE, if any input with valid=1 has prio_mask_i[k]=1, the winner is the cyclic-first among those masked inputs starting at rr_ptr.
  - Otherwise normal round-robin applies.
  - The mask is sampled only in IDLE; changing it during LOCK has no effect on the current burst.
- When undefined: the port is absent and selection is pure round-robin.

Test Plan:
- Single requester, push_i[2] valid for 6 beats, pop_o.ready=1, MAX_BURST=4 → 1 bubble, 4 beats on grant 2, IDLE 1 cycle, re-grant 2, 2 beats; output data order preserved.
- All 4 inputs continuously valid, MAX_BURST=2 → grant sequence 0,1,2,3,0 with 2 beats each and 1 bubble between bursts; no input starved.
- Grant 1, pop_o.ready=0 for 5 cycles mid-burst → pop_o.valid=1 with data held constant, burst_cnt unchanged; burst resumes and completes when ready returns.
- Grant 3, push_i[3].valid drops after 1 beat with ready=1 → release; rr_ptr=0; next grant goes to the next valid input cyclically from 0.
- rst_i asserted in LOCK after 2 of 4 beats → next cycle IDLE, busy_o=0, grant_idx_o=0, all readies 0; after release, arbitration restarts from input 0.
- With HWPE_STREAM_RR_PRIO_EN, inputs 0 and 2 valid, prio_mask_i=4'b0100, rr_ptr=0 → grant 2 first, then 0.

Source files
------------

// File: rtl/hwpe_stream_rr_burst_arbiter.sv
// Round-robin arbiter that locks one HWPE-Stream requester for up to MAX_BURST beats.
// Define HWPE_STREAM_RR_PRIO_EN to add prio_mask_i, which favours masked requesters in IDLE.
module hwpe_stream_rr_burst_arbiter #(
    parameter int unsigned NB_IN      = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_BURST  = 4,
    localparam int unsigned STRB_W    = DATA_WIDTH / 8,
    localparam int unsigned IDX_W     = $clog2(NB_IN),
    localparam int unsigned CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        clear_i,
`ifdef HWPE_STREAM_RR_PRIO_EN
    input  logic [NB_IN-1:0]            prio_mask_i,
`endif
    input  logic [NB_IN-1:0]            push_valid_i,
    output logic [NB_IN-1:0]            push_ready_o,
    input  logic [NB_IN*DATA_WIDTH-1:0] push_data_i,
    input  logic [NB_IN*STRB_W-1:0]     push_strb_i,
    output logic                        pop_valid_o,
    input  logic                        pop_ready_i,
    output logic [DATA_WIDTH-1:0]       pop_data_o,
    output logic [STRB_W-1:0]           pop_strb_o,
    output logic [IDX_W-1:0]            grant_idx_o,
    output logic                        busy_o
);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] ptr_inc;
    logic [NB_IN-1:0] cand;
    int unsigned      srch;
    logic             found;
    logic             g_valid;
    logic             beat;
    logic             last_beat;
    logic             dry;

`ifdef HWPE_STREAM_RR_PRIO_EN
    always_comb begin : prio_filter
        cand = push_valid_i & prio_mask_i;
        if (cand == '0) begin
            cand = push_valid_i;
        end
    end
`else
    assign cand = push_valid_i;
`endif

    // Cyclic first-one search starting at rr_ptr_q.
    always_comb begin : rr_search
        winner = '0;
        found  = 1'b0;
        srch   = 0;
        for (int unsigned i = 0; i < NB_IN; i++) begin
            srch = (32'(rr_ptr_q) + i) % NB_IN;
            if (!found && cand[IDX_W'(srch)]) begin
                found  = 1'b1;
                winner = IDX_W'(srch);
            end
        end
    end

    assign g_valid   = push_valid_i[grant_q];
    assign beat      = g_valid & pop_ready_i;
    assign dry       = ~g_valid & pop_ready_i;
    assign last_beat = (cnt_q == CNT_W'(MAX_BURST - 1));
    assign ptr_inc   = (grant_q == IDX_W'(NB_IN - 1)) ?
                       '0 : grant_q + IDX_W'(1);

    always_ff @(posedge clk_i) begin : state_reg
        if (rst_i || clear_i) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin : next_state
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = LOCK;
                    grant_d = winner;
                    cnt_d   = '0;
                end
            end
            LOCK: begin
                if ((beat && last_beat) || dry) begin
                    state_d  = IDLE;
                    rr_ptr_d = ptr_inc;
                    cnt_d    = '0;
                end else if (beat) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Data/strobe forced to zero whenever the granted source is not valid.
    always_comb begin : outputs
        push_ready_o = '0;
        pop_valid_o  = 1'b0;
        pop_data_o   = '0;
        pop_strb_o   = '0;
        busy_o       = 1'b0;
        grant_idx_o  = '0;
        case (state_q)
            LOCK: begin
                busy_o                = 1'b1;
                grant_idx_o           = grant_q;
                pop_valid_o           = g_valid;
                push_ready_o[grant_q] = pop_ready_i;
                if (g_valid) begin
                    pop_data_o = push_data_i[32'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
                    pop_strb_o = push_strb_i[32'(grant_q)*STRB_W +: STRB_W];
                end
            end
            default: begin
                push_ready_o = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_hwpe_stream_rr_burst_arbiter.sv
// Bench for hwpe_stream_rr_burst_arbiter: randomized sources and sink
// checked every cycle against a transaction-level arbitration model.
module tb_hwpe_stream_rr_burst_arbiter;

    localparam int NB = 4;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int MB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, clr;
    logic [NB-1:0]     pv, pr;
    logic [NB*DW-1:0]  pd;
    logic [NB*SW-1:0]  ps;
    logic              qv, qr;
    logic [DW-1:0]     qd;
    logic [SW-1:0]     qs;
    logic [1:0]        gidx;
    logic              busy;
`ifdef HWPE_STREAM_RR_PRIO_EN
    logic [NB-1:0]     pmask;
`endif

    hwpe_stream_rr_burst_arbiter #(
        .NB_IN      (NB),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .clear_i      (clr),
`ifdef HWPE_STREAM_RR_PRIO_EN
        .prio_mask_i  (pmask),
`endif
        .push_valid_i (pv),
        .push_ready_o (pr),
        .push_data_i  (pd),
        .push_strb_i  (ps),
        .pop_valid_o  (qv),
        .pop_ready_i  (qr),
        .pop_data_o   (qd),
        .pop_strb_o   (qs),
        .grant_idx_o  (gidx),
        .busy_o       (busy)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int left[NB];
    bit offer[NB];
    int seq[NB];
    int rcv[NB];
    int p_offer  = 100;
    int p_ready  = 100;
    int p_rst    = 0;
    bit hold_rst = 0;
    bit rnd_mask = 0;

    bit m_busy = 0;
    int m_own  = 0;
    int m_beats = 0;
    int m_next = 0;

    int glog[$];
    int vlog[$];
    int blog[$];
    int owners[$];

    function automatic logic [31:0] tag(int k, int s);
        return {k[3:0], s[27:0]};
    endfunction

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    function automatic int pick();
        logic [NB-1:0] c;
        c = pv;
`ifdef HWPE_STREAM_RR_PRIO_EN
        if ((pv & pmask) != '0) c = pv & pmask;
`endif
        for (int i = 0; i < NB; i++) begin
            if (c[(m_next + i) % NB]) return (m_next + i) % NB;
        end
        return -1;
    endfunction

    task automatic step();
        logic          e_valid;
        logic [DW-1:0] e_data;
        logic [SW-1:0] e_strb;
        logic [NB-1:0] e_ready;
        int            w;
        @(negedge clk);
        for (int k = 0; k < NB; k++) begin
            if (!offer[k] && left[k] > 0 && $urandom_range(0, 99) < p_offer)
                offer[k] = 1'b1;
            pv[k] = offer[k];
            pd[k*DW +: DW] = offer[k] ? tag(k, seq[k]) : DW'($urandom);
            ps[k*SW +: SW] = offer[k] ? SW'(k + 1) : SW'($urandom);
        end
        qr  = ($urandom_range(0, 99) < p_ready);
        rst = hold_rst | (p_rst > 0 && $urandom_range(0, 999) < p_rst);
        clr = (p_rst > 0 && $urandom_range(0, 999) < p_rst);
`ifdef HWPE_STREAM_RR_PRIO_EN
        pmask = rnd_mask ? NB'($urandom) : '0;
`endif
        #1;
        e_valid = 1'b0;
        e_data  = '0;
        e_strb  = '0;
        e_ready = '0;
        if (m_busy) begin
            e_valid = pv[m_own];
            e_ready[m_own] = qr;
            if (e_valid) begin
                e_data = tag(m_own, seq[m_own]);
                e_strb = SW'(m_own + 1);
            end
        end
        check("busy", 64'(busy), 64'(m_busy));
        check("grant", 64'(gidx), m_busy ? 64'(m_own) : 64'd0);
        check("pop_valid", 64'(qv), 64'(e_valid));
        check("pop_data", 64'(qd), 64'(e_data));
        check("pop_strb", 64'(qs), 64'(e_strb));
        check("push_ready", 64'(pr), 64'(e_ready));
        glog.push_back(int'(gidx));
        vlog.push_back(int'(qv));
        blog.push_back(int'(busy));
        for (int k = 0; k < NB; k++) begin
            if (pv[k] && e_ready[k]) begin
                check("order", 64'(qd), 64'(tag(k, rcv[k])));
                rcv[k]++;
                seq[k]++;
                left[k]--;
                offer[k] = 1'b0;
            end
        end
        @(posedge clk);
        if (rst || clr) begin
            m_busy  = 1'b0;
            m_next  = 0;
            m_beats = 0;
        end else if (!m_busy) begin
            w = pick();
            if (w >= 0) begin
                m_busy  = 1'b1;
                m_own   = w;
                m_beats = 0;
                owners.push_back(w);
            end
        end else if (pv[m_own] && qr) begin
            m_beats++;
            if (m_beats == MB) begin
                m_busy = 1'b0;
                m_next = (m_own + 1) % NB;
            end
        end else if (!pv[m_own] && qr) begin
            m_busy = 1'b0;
            m_next = (m_own + 1) % NB;
        end
        cyc++;
    endtask

    task automatic drain();
        int n;
        bit pend;
        n = 0;
        p_ready = 100;
        p_offer = 100;
        p_rst   = 0;
        pend    = 1'b1;
        while (pend && n < 600) begin
            step();
            n++;
            pend = m_busy;
            for (int k = 0; k < NB; k++) if (left[k] > 0) pend = 1'b1;
        end
        check("drain_timeout", 64'(pend), 64'd0);
    endtask

    initial begin
        int exp_g[10];
        int exp_v[10];
        int exp_o[8];
        int n, base;
        exp_g = '{0, 2, 2, 2, 2, 0, 2, 2, 2, 0};
        exp_v = '{0, 1, 1, 1, 1, 0, 1, 1, 0, 0};
        exp_o = '{0, 1, 2, 3, 0, 1, 2, 3};
        for (int k = 0; k < NB; k++) begin
            left[k] = 0; offer[k] = 0; seq[k] = 0; rcv[k] = 0;
        end
        pv = '0; pd = '0; ps = '0; qr = 1'b0;
        rst = 1'b1; clr = 1'b0;
`ifdef HWPE_STREAM_RR_PRIO_EN
        pmask = '0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_grant", 64'(gidx), 64'd0);
        check("reset_valid", 64'(qv), 64'd0);
        check("reset_ready", 64'(pr), 64'd0);
        rst = 1'b0;

        // single requester on input 2, six beats
        left[2] = 6;
        glog.delete(); vlog.delete();
        for (int i = 0; i < 10; i++) step();
        for (int i = 0; i < 10; i++) begin
            check("single_grant", 64'(glog[i]), 64'(exp_g[i]));
            check("single_valid", 64'(vlog[i]), 64'(exp_v[i]));
        end

        // all inputs busy from pointer 0
        hold_rst = 1'b1; step(); hold_rst = 1'b0;
        for (int k = 0; k < NB; k++) left[k] = 2 * MB;
        owners.delete();
        n = 0;
        while (owners.size() < 8 && n < 200) begin step(); n++; end
        check("rr_timeout", 64'(owners.size() >= 8), 64'd1);
        for (int i = 0; i < 8 && i < owners.size(); i++)
            check("rr_owner", 64'(owners[i]), 64'(exp_o[i]));
        drain();

        // reset mid-burst must also reset the round-robin pointer
        left[2] = 1;
        drain();
        left[1] = 10;
        base = rcv[1];
        n = 0;
        while (rcv[1] < base + 2 && n < 40) begin step(); n++; end
        check("midburst_timeout", 64'(rcv[1] >= base + 2), 64'd1);
        hold_rst = 1'b1; step(); hold_rst = 1'b0;
        left[3] = 2;
        blog.delete(); glog.delete(); vlog.delete(); owners.delete();
        step();
        check("post_rst_busy", 64'(blog[0]), 64'd0);
        check("post_rst_grant", 64'(glog[0]), 64'd0);
        check("post_rst_valid", 64'(vlog[0]), 64'd0);
        n = 0;
        while (owners.size() == 0 && n < 20) begin step(); n++; end
        check("post_rst_owner", owners.size() > 0 ? 64'(owners[0]) : 64'hff, 64'd1);
        drain();

        // randomized traffic with backpressure, dry sources, resets and clears
        p_offer = 40; p_ready = 60; p_rst = 4; rnd_mask = 1'b1;
        for (int k = 0; k < NB; k++) left[k] = $urandom_range(1, 12);
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < NB; k++)
                if (left[k] == 0 && $urandom_range(0, 49) == 0)
                    left[k] = $urandom_range(1, 12);
            if (c % 500 == 0) begin
                p_offer = $urandom_range(20, 100);
                p_ready = $urandom_range(20, 100);
            end
            step();
        end
        rnd_mask = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
